// File: rtl/rad_cdc_mcp_buf.sv
// Multi-slot MCP clock-domain crossing: data parked in a slot bank, per-slot toggle flags cross.
// Optional sticky protocol-error outputs aerr/berr under RAD_CDC_MCP_BUF_ERR_EN.
module rad_cdc_mcp_buf #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             bclk,
    input  logic             brst_n,
    input  logic [WIDTH-1:0] adatain,
    input  logic             asend,
    output logic             aready,
    output logic [WIDTH-1:0] bdata,
    output logic             bvalid,
`ifdef RAD_CDC_MCP_BUF_ERR_EN
    output logic             aerr,
    output logic             berr,
`endif
    input  logic             bload
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_aflag;
    logic [DEPTH-1:0] r_bflag;
    logic [DEPTH-1:0] r_bsync [SYNC_STAGES];
    logic [DEPTH-1:0] r_async [SYNC_STAGES];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;

    logic [DEPTH-1:0] w_bflag_a;
    logic [DEPTH-1:0] w_aflag_b;
    logic             w_aacc;
    logic             w_bacc;

    assign w_bflag_a = r_bsync[SYNC_STAGES-1];
    assign w_aflag_b = r_async[SYNC_STAGES-1];

    // A slot is free when both sides have toggled its flag the same number of times
    assign aready = (r_aflag[r_wptr] == w_bflag_a[r_wptr]);
    assign w_aacc = asend && aready;

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_aflag <= '0;
            r_wptr  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                r_bsync[i] <= '0;
        end else begin
            r_bsync[0] <= r_bflag;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_bsync[i] <= r_bsync[i-1];
            if (w_aacc) begin
                r_aflag[r_wptr] <= ~r_aflag[r_wptr];
                r_wptr          <= r_wptr + AW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst_n && w_aacc)
            r_mem[r_wptr] <= adatain;
    end

    assign bvalid = (r_bflag[r_rptr] != w_aflag_b[r_rptr]);
    assign w_bacc = bload && bvalid;
    // Slot contents are frozen while its flags disagree, so a direct read is safe
    assign bdata  = r_mem[r_rptr];

    always_ff @(posedge bclk) begin
        if (!brst_n) begin
            r_bflag <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                r_async[i] <= '0;
        end else begin
            r_async[0] <= r_aflag;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_async[i] <= r_async[i-1];
            if (w_bacc) begin
                r_bflag[r_rptr] <= ~r_bflag[r_rptr];
                r_rptr          <= r_rptr + AW'(1);
            end
        end
    end

`ifdef RAD_CDC_MCP_BUF_ERR_EN
    logic r_aerr;
    logic r_berr;

    always_ff @(posedge aclk) begin
        if (!arst_n)
            r_aerr <= 1'b0;
        else if (asend && !aready)
            r_aerr <= 1'b1;
    end

    always_ff @(posedge bclk) begin
        if (!brst_n)
            r_berr <= 1'b0;
        else if (bload && !bvalid)
            r_berr <= 1'b1;
    end

    assign aerr = r_aerr;
    assign berr = r_berr;
`endif

endmodule

// File: doc/rad_cdc_mcp_buf.md
Name: rad_cdc_mcp_buf

Overview:
Multi-slot multi-cycle-path (MCP) clock-domain crossing. It is the buffered successor to the single-register MCP synchroniser. Data words are held in a DEPTH-entry register bank written in the A domain and read in the B domain. Only per-slot toggle flags cross domains, so the A side can keep sending while earlier words are still in flight. Sits between independent-clock subsystems that need an ordered, lossless word stream with valid/ready-style handshakes.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 2: number of holding slots. Power of 2, >=2.
- SYNC_STAGES, 2: flip-flop stages per flag synchroniser, >=2.

Ports:
- aclk  in  1  A-domain clock.
- arst_n  in  1  A-domain reset, synchronous, active-low.
- bclk  in  1  B-domain clock.
- brst_n  in  1  B-domain reset, synchronous, active-low.
- adatain  in  WIDTH  A-side write data.
- asend  in  1  A-side write strobe; accepted only when aready=1.
- aready  out  1  A-side: the slot at wptr is free.
- bdata  out  WIDTH  B-side data for the slot at rptr.
- bvalid  out  1  B-side: the slot at rptr holds unread data.
- bload  in  1  B-side consume strobe; accepted only when bvalid=1.

Behaviour:
- Storage and flags:
  - mem[DEPTH] of WIDTH bits, written in the A domain only.
  - aflag[DEPTH] in the A domain; bflag[DEPTH] in the B domain.
  - Each flag vector is synchronised into the opposite domain through SYNC_STAGES flops per bit: aflag_b is aflag seen in B, bflag_a is bflag seen in A.
- Pointers: wptr (A domain) and rptr (B domain), each log2(DEPTH) bits. Both wrap naturally from DEPTH-1 to 0.
- aready = (aflag[wptr] == bflag_a[wptr]), combinational from registers.
- A-side accept: asend && aready at an aclk edge.
  - mem[wptr] <= adatain.
  - aflag[wptr] toggles.
  - wptr increments.
- asend while aready=0: ignored. No write, no state change.
- bvalid = (bflag[rptr] != aflag_b[rptr]).
- bdata = mem[rptr]. The slot is stable for the whole interval bvalid=1, so no B-side data register is needed.
- B-side accept: bload && bvalid at a bclk edge.
  - bflag[rptr] toggles.
  - rptr increments.
  - bvalid/bdata then reflect the next slot in the same cycle.
- bload while bvalid=0: ignored.
- Latency:
  - A accept to bvalid=1: SYNC_STAGES bclk edges after the first bclk edge that samples the new aflag. Worst case SYNC_STAGES+1 bclk edges.
  - bload to the slot reading free in A: at most SYNC_STAGES+1 aclk edges.
- Throughput: with DEPTH > 2*(SYNC_STAGES+1) and equal clocks, one word per cycle is sustained.
- Ordering: strict FIFO order, with no loss and no duplication.
- bdata is stable while bvalid=1 && bload=0.
- Full: all slots occupied drives aready=0 until a freed flag propagates back to A.
- Empty: bvalid=0 and bdata is don't-care.
- Simultaneous A write and B read on the same slot index cannot occur, because the flag protocol excludes it.
- Reset, A domain (arst_n=0 at an aclk edge): clears aflag, wptr and the bflag_a sync chain. mem is not reset. aready reads 1 during and immediately after reset; asend is ignored while arst_n=0.
- Reset, B domain (brst_n=0 at a bclk edge): clears bflag, rptr and the aflag_b sync chain. bvalid=0 during and immediately after reset.
- Reset mid-operation:
  - Both domains must be held in reset overlapping, for >= SYNC_STAGES+2 edges of the slower clock.
  - All in-flight words are discarded.
  - After release, no stale word may appear on bvalid.

Optional Feature:
- Macro: RAD_CDC_MCP_BUF_ERR_EN.
- Defined:
  - Adds output aerr (1 bit, A domain), a sticky flag set by asend && !aready && arst_n.
  - Adds output berr (1 bit, B domain), a sticky flag set by bload && !bvalid && brst_n.
  - Each is cleared only by its domain's reset; reset value 0.
- Undefined: the ports are absent and protocol violations are silently ignored.

Test Plan (WIDTH=8, DEPTH=4, SYNC_STAGES=2 unless stated):
1. Single send 0xA5, bload held 0 → bvalid=1 within 3 bclk edges with bdata=0xA5, held stable for 20 bclk cycles. Then bload=1 for one cycle → bvalid=0 at the next edge.
2. Back-to-back sends 0x01..0x04 with bload=0 → aready=0 after the 4th accept. A 5th asend of 0x05 is dropped. The B side then reads 0x01,0x02,0x03,0x04, followed by bvalid=0.
3. Full FIFO, one bload → aready returns to 1 within 3 aclk edges. A new send of 0x10 is read after 0x02..0x04.
4. aclk:bclk ratios 3:1 and 1:3, DEPTH=8, 256 random words with random asend/bload → B sequence equals A sequence exactly, no loss or duplication.
5. Both resets asserted mid-burst (2 words in flight) for 6 slow-clock edges → aready=1, bvalid=0 after release. The next sent word 0x5A is the first and only word received.
6. With RAD_CDC_MCP_BUF_ERR_EN: asend while full → aerr=1 and stays 1 until arst_n. bload while empty → berr=1. Without the macro, the same stimulus produces no state change.
